// File: rtl/hybrid_link_arbiter.sv
// Round-robin arbiter sharing one parity-protected byte channel between two 32-bit word
// sources; each granted word is framed by ready/ack and sent as four bytes, MSB first.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; arbitrate pending requests
// REQ   | owner granted, ready raised, waiting for sink ack
// SEND  | byte k on data_9, waiting for sink count to reach k+1
// GAP   | idle spacing between bytes, data_9 forced to zero
// DONE  | one-cycle completion pulse to the owner
module hybrid_link_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [31:0] word_a,
    output logic        grant_a,
    output logic        done_a,
    input  logic        req_b,
    input  logic [31:0] word_b,
    output logic        grant_b,
    output logic        done_b,
    output logic        ready,
    input  logic        ack,
    output logic [8:0]  data_9,
    input  logic [1:0]  nxt_data,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic        OWN_A    = 1'b0;
    localparam logic        OWN_B    = 1'b1;
    localparam logic [7:0]  TO_VAL   = 8'(TIMEOUT);
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t      state;
    logic        owner;
    logic        last_owner;
    logic [31:0] word_q;
    logic [1:0]  k;
    logic [7:0]  cnt;
    logic [15:0] gap_cnt;

    logic [1:0]  target;
    logic        hit;
    logic        timed_out;
    logic        cnt_last;
    logic        winner_b;

    function automatic logic [8:0] pack_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return {b, ^b};
    endfunction

    // Byte 3's target wraps to 0 through the 2-bit add.
    assign target    = k + 2'd1;
    assign hit       = (nxt_data == target);
    assign timed_out = (cnt == TO_VAL);
    assign cnt_last  = ((cnt + 8'd1) == TO_VAL);
    assign winner_b  = req_b & (~req_a | (last_owner == OWN_A));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            owner       <= OWN_A;
            last_owner  <= OWN_B;
            word_q      <= '0;
            k           <= '0;
            cnt         <= '0;
            gap_cnt     <= '0;
            grant_a     <= 1'b0;
            grant_b     <= 1'b0;
            done_a      <= 1'b0;
            done_b      <= 1'b0;
            ready       <= 1'b0;
            data_9      <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done_a      <= 1'b0;
            done_b      <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_a || req_b) begin
                        state   <= S_REQ;
                        owner   <= winner_b;
                        word_q  <= winner_b ? word_b : word_a;
                        grant_a <= ~winner_b;
                        grant_b <= winner_b;
                        ready   <= 1'b1;
                        busy    <= 1'b1;
                        k       <= '0;
                        cnt     <= '0;
                    end
                end

                S_REQ: begin
                    if (timed_out) begin
                        state      <= S_IDLE;
                        grant_a    <= 1'b0;
                        grant_b    <= 1'b0;
                        busy       <= 1'b0;
                        ready      <= 1'b0;
                        data_9     <= '0;
                        cnt        <= '0;
                        last_owner <= owner;
                    end else if (ack) begin
                        state  <= S_SEND;
                        ready  <= 1'b0;
                        cnt    <= '0;
                        data_9 <= pack_byte(word_q, 2'd0);
                    end else begin
                        cnt <= cnt + 8'd1;
                        // ready drops on the pulse cycle so it is high exactly TIMEOUT cycles
                        if (cnt_last) begin
                            timeout_err <= 1'b1;
                            ready       <= 1'b0;
                        end
                    end
                end

                S_SEND: begin
                    if (timed_out) begin
                        state      <= S_IDLE;
                        grant_a    <= 1'b0;
                        grant_b    <= 1'b0;
                        busy       <= 1'b0;
                        data_9     <= '0;
                        cnt        <= '0;
                        last_owner <= owner;
                    end else if (hit) begin
                        cnt <= '0;
                        if (k == 2'd3) begin
                            state  <= S_DONE;
                            data_9 <= '0;
                            if (owner == OWN_B) begin
                                done_b <= 1'b1;
                            end else begin
                                done_a <= 1'b1;
                            end
                        end else begin
                            k <= target;
                            if (GAP_CYCLES == 0) begin
                                data_9 <= pack_byte(word_q, target);
                            end else begin
                                state   <= S_GAP;
                                data_9  <= '0;
                                gap_cnt <= '0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt_last) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= S_SEND;
                        cnt    <= '0;
                        data_9 <= pack_byte(word_q, k);
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                S_DONE: begin
                    state      <= S_IDLE;
                    grant_a    <= 1'b0;
                    grant_b    <= 1'b0;
                    busy       <= 1'b0;
                    cnt        <= '0;
                    last_owner <= owner;
                end

                default: begin
                    state   <= S_IDLE;
                    grant_a <= 1'b0;
                    grant_b <= 1'b0;
                    busy    <= 1'b0;
                    ready   <= 1'b0;
                    data_9  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hybrid_link_arbiter.sv
// Directed bench for hybrid_link_arbiter: one instance with gaps and a short timeout,
// one with zero gap cycles.
module tb_hybrid_link_arbiter;

    logic        clk;
    logic        rst;
    logic        req_a, req_b, ack;
    logic [31:0] word_a, word_b;
    logic [1:0]  nxt_data;
    logic        grant_a, grant_b, done_a, done_b, ready, busy, timeout_err;
    logic [8:0]  data_9;

    logic        req0_a, req0_b, ack0;
    logic [1:0]  nxt0;
    logic        grant0_a, grant0_b, done0_a, done0_b, ready0, busy0, terr0;
    logic [8:0]  data0_9;

    int checks;
    int errors;

    hybrid_link_arbiter #(.GAP_CYCLES(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .word_a(word_a), .grant_a(grant_a), .done_a(done_a),
        .req_b(req_b), .word_b(word_b), .grant_b(grant_b), .done_b(done_b),
        .ready(ready), .ack(ack), .data_9(data_9), .nxt_data(nxt_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    hybrid_link_arbiter #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_a(req0_a), .word_a(word_a), .grant_a(grant0_a), .done_a(done0_a),
        .req_b(req0_b), .word_b(word_b), .grant_b(grant0_b), .done_b(done0_b),
        .ready(ready0), .ack(ack0), .data_9(data0_9), .nxt_data(nxt0),
        .busy(busy0), .timeout_err(terr0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serves one frame with a sink that acks at once and accepts each byte a cycle late.
    task automatic run_frame(input bit is_b, input bit drop,
                             input logic [8:0] e0, input logic [8:0] e1,
                             input logic [8:0] e2, input logic [8:0] e3);
        logic [8:0] e [4];
        e = '{e0, e1, e2, e3};
        tick();
        chk("req_grant_own",   is_b ? grant_b : grant_a, 1);
        chk("req_grant_other", is_b ? grant_a : grant_b, 0);
        chk("req_ready", ready, 1);
        chk("req_busy", busy, 1);
        if (drop) begin
            if (is_b) req_b = 0; else req_a = 0;
        end
        if (is_b) word_b = 32'hDEADBEEF; else word_a = 32'hDEADBEEF;
        ack = 1;
        tick();
        ack = 0;
        chk("send_ready_low", ready, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("byte%0d", k), data_9, e[k]);
            tick();
            chk($sformatf("byte%0d_held", k), data_9, e[k]);
            nxt_data = 2'(k + 1);
            tick();
            if (k < 3) begin
                chk($sformatf("gap%0d_data", k), data_9, 0);
                tick();
                tick();
            end
        end
        chk("done_own",   is_b ? done_b : done_a, 1);
        chk("done_other", is_b ? done_a : done_b, 0);
        chk("done_grant", is_b ? grant_b : grant_a, 1);
        tick();
        chk("idle_done_low", is_b ? done_b : done_a, 0);
        chk("idle_grant_low", is_b ? grant_b : grant_a, 0);
        chk("idle_busy_low", busy, 0);
    endtask

    initial begin
        logic [8:0] exp_b [4];
        exp_b = '{9'h024, 9'h069, 9'h0AC, 9'h0F0};
        clk = 0; rst = 0;
        req_a = 0; req_b = 0; ack = 0; nxt_data = 0;
        word_a = 0; word_b = 0;
        req0_a = 0; req0_b = 0; ack0 = 0; nxt0 = 0;
        checks = 0; errors = 0;

        repeat (2) tick();
        chk("rst_grant_a", grant_a, 0);
        chk("rst_grant_b", grant_b, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_done_b", done_b, 0);
        chk("rst_ready", ready, 0);
        chk("rst_data", data_9, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_busy0", busy0, 0);
        rst = 1;
        tick();

        // single frame from A
        word_a = 32'h12345678; req_a = 1;
        run_frame(0, 1, 9'h024, 9'h069, 9'h0AC, 9'h0F0);

        // contention straight out of reset: A first, then B after a one-cycle bubble
        rst = 0; tick(); rst = 1; tick();
        word_a = 32'h12345678; word_b = 32'hA5A5A5A5;
        req_a = 1; req_b = 1;
        run_frame(0, 1, 9'h024, 9'h069, 9'h0AC, 9'h0F0);
        run_frame(1, 1, 9'h14A, 9'h14A, 9'h14A, 9'h14A);

        // both held: grants alternate
        word_a = 32'h12345678; word_b = 32'hA5A5A5A5;
        req_a = 1; req_b = 1;
        run_frame(0, 0, 9'h024, 9'h069, 9'h0AC, 9'h0F0);
        word_a = 32'h12345678;
        run_frame(1, 0, 9'h14A, 9'h14A, 9'h14A, 9'h14A);
        word_b = 32'hA5A5A5A5;
        run_frame(0, 0, 9'h024, 9'h069, 9'h0AC, 9'h0F0);
        word_a = 32'h12345678;
        run_frame(1, 0, 9'h14A, 9'h14A, 9'h14A, 9'h14A);
        req_a = 0; req_b = 0;
        word_b = 32'hA5A5A5A5;

        // ack timeout: ready high exactly 4 cycles, then A loses the next contention
        req_a = 1;
        tick();
        chk("to_grant_a", grant_a, 1);
        req_a = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_ready_c%0d", i), ready, 1);
            chk($sformatf("to_terr_c%0d", i), timeout_err, 0);
            tick();
        end
        chk("to_ready_end", ready, 0);
        chk("to_terr_pulse", timeout_err, 1);
        chk("to_no_done", done_a, 0);
        req_a = 1; req_b = 1;
        tick();
        chk("to_terr_clear", timeout_err, 0);
        chk("to_busy_low", busy, 0);
        chk("to_grant_drop", grant_a, 0);
        chk("to_no_done_late", done_a, 0);
        tick();
        chk("to_next_b", grant_b, 1);
        chk("to_next_not_a", grant_a, 0);
        req_a = 0; req_b = 0;
        repeat (4) tick();
        chk("to_b_terr", timeout_err, 1);
        chk("to_b_no_done", done_b, 0);
        tick();
        chk("to_b_idle", busy, 0);

        // sink stalls at count 2: byte 2 held until timeout
        word_a = 32'h12345678; nxt_data = 0; req_a = 1;
        tick();
        chk("st_grant", grant_a, 1);
        req_a = 0; ack = 1;
        tick();
        ack = 0;
        chk("st_b0", data_9, 9'h024);
        nxt_data = 1;
        repeat (3) tick();
        chk("st_b1", data_9, 9'h069);
        nxt_data = 2;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("st_b2_c%0d", i), data_9, 9'h0AC);
            chk($sformatf("st_terr_c%0d", i), timeout_err, 0);
            tick();
        end
        chk("st_terr_pulse", timeout_err, 1);
        chk("st_busy_at_to", busy, 1);
        chk("st_b2_at_to", data_9, 9'h0AC);
        chk("st_no_done", done_a, 0);
        tick();
        chk("st_busy_low", busy, 0);
        chk("st_grant_low", grant_a, 0);
        chk("st_data_low", data_9, 0);

        // reset while byte 1 is on the channel
        nxt_data = 0; req_a = 1;
        tick();
        req_a = 0; ack = 1;
        tick();
        ack = 0; nxt_data = 1;
        repeat (3) tick();
        chk("mr_b1", data_9, 9'h069);
        #2 rst = 0;
        #1;
        chk("mr_grant_a", grant_a, 0);
        chk("mr_busy", busy, 0);
        chk("mr_data", data_9, 0);
        chk("mr_ready", ready, 0);
        chk("mr_done", done_a, 0);
        chk("mr_terr", timeout_err, 0);
        req_a = 1; req_b = 1; nxt_data = 0;
        tick();
        rst = 1;
        tick();
        chk("mr_a_wins", grant_a, 1);
        chk("mr_b_loses", grant_b, 0);
        req_a = 0; req_b = 0;
        repeat (5) tick();
        chk("mr_idle", busy, 0);

        // zero-gap instance: bytes on consecutive cycles, 6-cycle frame
        word_a = 32'h12345678;
        req0_a = 1; ack0 = 1;
        tick();
        chk("g0_grant", grant0_a, 1);
        chk("g0_ready", ready0, 1);
        chk("g0_busy_c1", busy0, 1);
        req0_a = 0;
        tick();
        ack0 = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("g0_byte%0d", k), data0_9, exp_b[k]);
            chk($sformatf("g0_busy_c%0d", k + 2), busy0, 1);
            chk($sformatf("g0_nodone_c%0d", k + 2), done0_a, 0);
            nxt0 = 2'(k + 1);
            tick();
        end
        chk("g0_done", done0_a, 1);
        chk("g0_busy_c6", busy0, 1);
        chk("g0_grant_c6", grant0_a, 1);
        tick();
        chk("g0_idle", busy0, 0);
        chk("g0_done_low", done0_a, 0);
        chk("g0_grant_low", grant0_a, 0);
        chk("g0_no_terr", terr0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
